// File: rtl/sdram_arb_pkg.sv
// Shared widths, state encoding and index helper for the SDRAM burst arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W  = 26;
    localparam int DATA_W  = 32;
    localparam int GRANT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    // Index following idx, wrapping back to 0 after numReq-1.
    function automatic logic [GRANT_W-1:0] nextIndex(input logic [GRANT_W-1:0] idx,
                                                     input int numReq);
        if (int'(idx) >= numReq - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr_i, wrapping.
module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] request_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [GRANT_W-1:0] winner_o,
    output logic               valid_o
);

    // Offsets are walked from farthest to nearest so the request closest to ptr_i is kept last.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (int'(ptr_i) + off) % NUM_REQ && request_i[i]) begin
                    winner_o = GRANT_W'(i);
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Shares the SDRAM controller's read-burst port between NUM_REQ clients, one burst in flight,
// with optional absolute priority for port 0 and a sticky protocol-violation flag.
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 8,
    parameter int PRIORITY0 = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ-1:0]        req_request,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_data,
    output logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_complete,
    output logic [ADDR_W-1:0]         sdram_address,
    output logic                      sdram_request,
    input  logic [DATA_W-1:0]         sdram_data,
    input  logic                      sdram_valid,
    input  logic                      sdram_ack,
    input  logic                      sdram_complete,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      busy,
    output logic                      proto_error
);

    localparam int               CNT_W       = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    arb_state_e         state_q;
    logic [GRANT_W-1:0] grant_q;
    logic [GRANT_W-1:0] rrPtr_q;
    logic [ADDR_W-1:0]  sdramAddr_q;
    logic               sdramReq_q;
    logic               protoErr_q;
    logic [CNT_W-1:0]   beatCnt_q;
    logic [CNT_W-1:0]   beatCnt_d;

    logic [GRANT_W-1:0] rrWinner;
    logic               rrValid;
    logic [GRANT_W-1:0] winner;
    logic [GRANT_W-1:0] nextPtr;
    logic [ADDR_W-1:0]  winnerAddr;
    logic               beatValid;
    logic               burstDone;
    logic               errNow;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) uRrArbiter (
        .request_i (req_request),
        .ptr_i     (rrPtr_q),
        .winner_o  (rrWinner),
        .valid_o   (rrValid)
    );

    always_comb begin
        winner = rrWinner;
        if (PRIORITY0 != 0 && req_request[0]) begin
            winner = '0;
        end
        nextPtr    = nextIndex(winner, NUM_REQ);
        winnerAddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == GRANT_W'(i)) begin
                winnerAddr = req_address[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // A beat arriving together with complete is counted before the length check.
    always_comb begin
        beatValid = (state_q == BURST) && sdram_valid;
        burstDone = (state_q == BURST) && sdram_complete;
        beatCnt_d = beatCnt_q + CNT_W'(beatValid);
        errNow    = 1'b0;
        if (state_q != BURST && (sdram_valid || sdram_complete)) begin
            errNow = 1'b1;
        end
        if (state_q != REQ && sdram_ack) begin
            errNow = 1'b1;
        end
        if (beatValid && beatCnt_q >= BURST_LEN_C) begin
            errNow = 1'b1;
        end
        if (burstDone && beatCnt_d != BURST_LEN_C) begin
            errNow = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rrPtr_q     <= '0;
            sdramAddr_q <= '0;
            sdramReq_q  <= 1'b0;
            protoErr_q  <= 1'b0;
            beatCnt_q   <= '0;
        end else begin
            if (errNow) begin
                protoErr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rrValid) begin
                        grant_q     <= winner;
                        sdramAddr_q <= winnerAddr;
                        sdramReq_q  <= 1'b1;
                        rrPtr_q     <= nextPtr;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdramReq_q <= 1'b0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    beatCnt_q <= beatCnt_d;
                    if (sdram_complete) begin
                        beatCnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Client-side strobes go only to the current owner and only in the state that owns them.
    always_comb begin
        req_ack      = '0;
        req_valid    = '0;
        req_complete = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                req_ack[i]      = (state_q == REQ) && sdram_ack;
                req_valid[i]    = beatValid;
                req_complete[i] = burstDone;
            end
        end
    end

    assign req_data      = (state_q == BURST) ? sdram_data : '0;
    assign sdram_address = sdramAddr_q;
    assign sdram_request = sdramReq_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign proto_error   = protoErr_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Scoreboard bench: a priority instance and a pure round-robin instance share one SDRAM/client
// stimulus bus, and only the instance selected by sel sees it.
module tb_sdram_burst_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 26;

    typedef struct {
        int          port;
        logic [31:0] data;
    } beat_t;

    logic                      clock;
    logic                      reset;
    logic [NUM_REQ*ADDR_W-1:0] drvAddr;
    logic [NUM_REQ-1:0]        drvReq;
    logic [31:0]               drvData;
    logic                      drvValid;
    logic                      drvAck;
    logic                      drvComplete;
    int                        sel;
    logic [ADDR_W-1:0]         portAddr [NUM_REQ];

    logic [NUM_REQ-1:0] pReq, rReq;
    logic [31:0]        pSdData, rSdData;
    logic               pSdValid, rSdValid, pSdAck, rSdAck, pSdComp, rSdComp;

    logic [NUM_REQ-1:0] pAck, pValid, pComplete, rAck, rValid, rComplete;
    logic [31:0]        pData, rData;
    logic [ADDR_W-1:0]  pSdAddr, rSdAddr;
    logic               pSdReq, rSdReq, pBusy, rBusy, pErr, rErr;
    logic [2:0]         pGrant, rGrant;

    logic [NUM_REQ-1:0] vAck, vValid, vComplete;
    logic [31:0]        vData;
    logic [ADDR_W-1:0]  vSdAddr;
    logic               vSdReq, vBusy, vErr;
    logic [2:0]         vGrant;

    int    checks = 0;
    int    errors = 0;
    beat_t expQ[$];
    int    completeCnt [NUM_REQ];
    int    reqRise = 0;
    logic  prevSdReq = 1'b0;

    assign pReq     = (sel == 0) ? drvReq      : '0;
    assign pSdData  = (sel == 0) ? drvData     : '0;
    assign pSdValid = (sel == 0) ? drvValid    : 1'b0;
    assign pSdAck   = (sel == 0) ? drvAck      : 1'b0;
    assign pSdComp  = (sel == 0) ? drvComplete : 1'b0;
    assign rReq     = (sel != 0) ? drvReq      : '0;
    assign rSdData  = (sel != 0) ? drvData     : '0;
    assign rSdValid = (sel != 0) ? drvValid    : 1'b0;
    assign rSdAck   = (sel != 0) ? drvAck      : 1'b0;
    assign rSdComp  = (sel != 0) ? drvComplete : 1'b0;

    assign vAck      = (sel != 0) ? rAck      : pAck;
    assign vValid    = (sel != 0) ? rValid    : pValid;
    assign vComplete = (sel != 0) ? rComplete : pComplete;
    assign vData     = (sel != 0) ? rData     : pData;
    assign vSdAddr   = (sel != 0) ? rSdAddr   : pSdAddr;
    assign vSdReq    = (sel != 0) ? rSdReq    : pSdReq;
    assign vBusy     = (sel != 0) ? rBusy     : pBusy;
    assign vErr      = (sel != 0) ? rErr      : pErr;
    assign vGrant    = (sel != 0) ? rGrant    : pGrant;

    sdram_burst_arbiter #(.NUM_REQ(NUM_REQ), .BURST_LEN(8), .PRIORITY0(1)) dutPrio (
        .clock(clock), .reset(reset), .req_address(drvAddr), .req_request(pReq),
        .req_ack(pAck), .req_data(pData), .req_valid(pValid), .req_complete(pComplete),
        .sdram_address(pSdAddr), .sdram_request(pSdReq), .sdram_data(pSdData),
        .sdram_valid(pSdValid), .sdram_ack(pSdAck), .sdram_complete(pSdComp),
        .grant_id(pGrant), .busy(pBusy), .proto_error(pErr)
    );

    sdram_burst_arbiter #(.NUM_REQ(NUM_REQ), .BURST_LEN(8), .PRIORITY0(0)) dutRr (
        .clock(clock), .reset(reset), .req_address(drvAddr), .req_request(rReq),
        .req_ack(rAck), .req_data(rData), .req_valid(rValid), .req_complete(rComplete),
        .sdram_address(rSdAddr), .sdram_request(rSdReq), .sdram_data(rSdData),
        .sdram_valid(rSdValid), .sdram_ack(rSdAck), .sdram_complete(rSdComp),
        .grant_id(rGrant), .busy(rBusy), .proto_error(rErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [NUM_REQ-1:0] onehot(input int p);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    // Every routed beat must match the oldest expected beat for the selected instance.
    always @(negedge clock) begin : monitor
        beat_t b;
        if (vValid !== '0) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_valid: req_valid=%b data=%h, no beat expected", vValid, vData);
            end else begin
                b = expQ.pop_front();
                if (vValid !== onehot(b.port) || vData !== b.data) begin
                    errors++;
                    $display("[TB] FAIL beat: req_valid=%b data=%h, expected valid=%b data=%h",
                             vValid, vData, onehot(b.port), b.data);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vComplete[i] === 1'b1) completeCnt[i]++;
        end
        if (vSdReq === 1'b1 && prevSdReq !== 1'b1) reqRise++;
        prevSdReq = vSdReq;
    end

    task automatic clearDrive();
        drvReq      = '0;
        drvData     = '0;
        drvValid    = 1'b0;
        drvAck      = 1'b0;
        drvComplete = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clock); #1;
        reset = 1'b0;
        clearDrive();
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // Acts as the SDRAM controller for one burst owned by port.
    task automatic serveBurst(input int port, input int nBeats, input logic [31:0] base,
                              input bit reReq, input bit holdOver, input bit lastWithComplete);
        int    n;
        beat_t b;
        n = 0;
        while (vSdReq !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("[TB] FAIL request_timeout: sdram_request=%b, expected 1 for port %0d", vSdReq, port);
            clearDrive();
            return;
        end
        checks++;
        if (vGrant !== 3'(port)) begin
            errors++;
            $display("[TB] FAIL grant: grant_id=%0d, expected %0d", vGrant, port);
        end
        checks++;
        if (vSdAddr !== portAddr[port]) begin
            errors++;
            $display("[TB] FAIL address: sdram_address=%h, expected %h", vSdAddr, portAddr[port]);
        end
        @(posedge clock); #1;
        drvAck = 1'b1;
        @(negedge clock);
        checks++;
        if (vAck !== onehot(port)) begin
            errors++;
            $display("[TB] FAIL ack: req_ack=%b, expected %b", vAck, onehot(port));
        end
        @(posedge clock); #1;
        drvAck = 1'b0;
        if (!holdOver) drvReq[port] = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            if (i > 0) begin
                @(posedge clock); #1;
            end
            if (holdOver && i == 1) drvReq[port] = 1'b0;
            drvValid    = 1'b1;
            drvData     = base + 32'(i);
            drvComplete = lastWithComplete && (i == nBeats - 1);
            b.port      = port;
            b.data      = base + 32'(i);
            expQ.push_back(b);
            @(negedge clock);
        end
        if (!lastWithComplete) begin
            @(posedge clock); #1;
            drvValid    = 1'b0;
            drvComplete = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (vComplete !== onehot(port)) begin
            errors++;
            $display("[TB] FAIL complete: req_complete=%b, expected %b", vComplete, onehot(port));
        end
        @(posedge clock); #1;
        drvValid    = 1'b0;
        drvComplete = 1'b0;
        if (reReq) drvReq[port] = 1'b1;
        @(negedge clock);
        checks++;
        if (vBusy !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL after_burst: busy=%b pending_beats=%0d, expected busy=0 pending=0",
                     vBusy, expQ.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clearDrive();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({pBusy, pSdReq, pErr} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_prio_flags: busy,req,err=%b, expected 000", {pBusy, pSdReq, pErr});
        end
        checks++;
        if (pGrant !== 3'd0 || pSdAddr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_prio_regs: grant=%0d addr=%h, expected 0 0", pGrant, pSdAddr);
        end
        checks++;
        if ({pAck, pValid, pComplete} !== '0 || pData !== '0) begin
            errors++;
            $display("[TB] FAIL reset_prio_client: ack/valid/complete=%b data=%h, expected 0",
                     {pAck, pValid, pComplete}, pData);
        end
        checks++;
        if ({rBusy, rSdReq, rErr, rGrant} !== '0 || rSdAddr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rr: busy,req,err,grant=%b addr=%h, expected 0",
                     {rBusy, rSdReq, rErr, rGrant}, rSdAddr);
        end
    endtask

    task automatic test_single_client();
        sel = 0;
        @(posedge clock); #1;
        drvReq[1] = 1'b1;
        @(negedge clock);
        checks++;
        if (vSdReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_early: sdram_request=%b before edge, expected 0", vSdReq);
        end
        @(negedge clock);
        checks++;
        if (vSdReq !== 1'b1 || vSdAddr !== 26'h0001240) begin
            errors++;
            $display("[TB] FAIL latency: req=%b addr=%h, expected 1 0001240", vSdReq, vSdAddr);
        end
        serveBurst(1, 8, 32'h000000A0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vErr !== 1'b0 || completeCnt[1] != 1) begin
            errors++;
            $display("[TB] FAIL single_client: proto_error=%b completes=%0d, expected 0 1", vErr, completeCnt[1]);
        end
    endtask

    task automatic test_hold_over();
        int rises;
        int comps;
        sel   = 0;
        rises = reqRise;
        comps = completeCnt[3];
        @(posedge clock); #1;
        drvReq[3] = 1'b1;
        serveBurst(3, 8, 32'h000000B0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clock);
        checks++;
        if (reqRise - rises != 1 || completeCnt[3] - comps != 1 || vErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_over: bursts=%0d completes=%0d err=%b, expected 1 1 0",
                     reqRise - rises, completeCnt[3] - comps, vErr);
        end
    endtask

    task automatic test_priority();
        sel = 0;
        @(posedge clock); #1;
        drvReq[0] = 1'b1;
        drvReq[2] = 1'b1;
        serveBurst(0, 8, 32'h10000000, 1'b1, 1'b0, 1'b0);
        serveBurst(0, 8, 32'h10000010, 1'b0, 1'b0, 1'b0);
        serveBurst(2, 8, 32'h20000000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        sel = 1;
        @(posedge clock); #1;
        drvReq = 4'b1110;
        serveBurst(1, 8, 32'h30000000, 1'b1, 1'b0, 1'b0);
        serveBurst(2, 8, 32'h30000100, 1'b0, 1'b0, 1'b0);
        serveBurst(3, 8, 32'h30000200, 1'b0, 1'b0, 1'b0);
        serveBurst(1, 8, 32'h30000300, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_no_starvation();
        sel = 1;
        @(posedge clock); #1;
        drvReq[0] = 1'b1;
        drvReq[2] = 1'b1;
        serveBurst(2, 8, 32'h40000000, 1'b0, 1'b0, 1'b0);
        drvReq[2] = 1'b1;
        serveBurst(0, 8, 32'h40000100, 1'b1, 1'b0, 1'b0);
        serveBurst(2, 8, 32'h40000200, 1'b0, 1'b0, 1'b0);
        serveBurst(0, 8, 32'h40000300, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_short_burst();
        sel = 0;
        checks++;
        if (vErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_before_short: proto_error=%b, expected 0", vErr);
        end
        @(posedge clock); #1;
        drvReq[1] = 1'b1;
        serveBurst(1, 7, 32'h50000000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vErr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL short_burst: proto_error=%b, expected 1", vErr);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (vErr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sticky: proto_error=%b, expected 1", vErr);
        end
    endtask

    task automatic test_stray();
        pulseReset();
        sel = 0;
        @(posedge clock); #1;
        drvValid = 1'b1;
        drvData  = 32'hDEADBEEF;
        @(negedge clock);
        checks++;
        if (pValid !== '0 || pData !== '0) begin
            errors++;
            $display("[TB] FAIL stray_valid: req_valid=%b data=%h, expected 0 0", pValid, pData);
        end
        @(posedge clock); #1;
        drvValid    = 1'b0;
        drvComplete = 1'b1;
        @(negedge clock);
        checks++;
        if (pComplete !== '0) begin
            errors++;
            $display("[TB] FAIL stray_complete: req_complete=%b, expected 0", pComplete);
        end
        @(posedge clock); #1;
        drvComplete = 1'b0;
        @(negedge clock);
        checks++;
        if (pErr !== 1'b1 || pBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_err: proto_error=%b busy=%b, expected 1 0", pErr, pBusy);
        end
        sel = 1;
        checks++;
        if (rErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_err_clean: proto_error=%b, expected 0", rErr);
        end
        @(posedge clock); #1;
        drvAck = 1'b1;
        @(negedge clock);
        checks++;
        if (rAck !== '0) begin
            errors++;
            $display("[TB] FAIL stray_ack: req_ack=%b, expected 0", rAck);
        end
        @(posedge clock); #1;
        drvAck = 1'b0;
        @(negedge clock);
        checks++;
        if (rErr !== 1'b1 || rBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_ack_err: proto_error=%b busy=%b, expected 1 0", rErr, rBusy);
        end
    endtask

    task automatic test_long_burst();
        pulseReset();
        sel = 1;
        @(posedge clock); #1;
        drvReq[1] = 1'b1;
        serveBurst(1, 9, 32'h60000000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rErr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL long_burst: proto_error=%b, expected 1", rErr);
        end
    endtask

    task automatic test_reset_mid_burst();
        int    comps;
        beat_t b;
        sel   = 0;
        comps = completeCnt[2];
        @(posedge clock); #1;
        drvReq[2] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (vSdReq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_req: sdram_request=%b, expected 1", vSdReq);
        end
        @(posedge clock); #1;
        drvAck = 1'b1;
        @(posedge clock); #1;
        drvAck    = 1'b0;
        drvReq[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clock); #1;
            end
            drvValid = 1'b1;
            drvData  = 32'h000000C0 + 32'(i);
            if (i == 3) reset = 1'b0;
            b.port = 2;
            b.data = 32'h000000C0 + 32'(i);
            expQ.push_back(b);
            @(negedge clock);
        end
        @(posedge clock); #1;
        reset    = 1'b1;
        drvValid = 1'b0;
        @(negedge clock);
        checks++;
        if (vBusy !== 1'b0 || vSdReq !== 1'b0 || vGrant !== 3'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: busy=%b req=%b grant=%0d, expected 0 0 0",
                     vBusy, vSdReq, vGrant);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (completeCnt[2] != comps || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_complete: completes=%0d pending=%0d, expected %0d 0",
                     completeCnt[2], expQ.size(), comps);
        end
        @(posedge clock); #1;
        drvReq[2] = 1'b1;
        serveBurst(2, 8, 32'h000000E0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_err: proto_error=%b, expected 0", vErr);
        end
    endtask

    initial begin
        sel = 0;
        for (int i = 0; i < NUM_REQ; i++) completeCnt[i] = 0;
        portAddr[0] = 26'h0A00000;
        portAddr[1] = 26'h0001240;
        portAddr[2] = 26'h02FFFE7;
        portAddr[3] = 26'h3FFFFE0;
        for (int i = 0; i < NUM_REQ; i++) drvAddr[i*ADDR_W +: ADDR_W] = portAddr[i];

        test_reset();
        test_single_client();
        test_hold_over();
        test_priority();
        test_round_robin();
        test_no_starvation();
        test_short_burst();
        test_stray();
        test_long_burst();
        test_reset_mid_burst();

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
